// File: rtl/affine_qpel_filter_pipe.sv
// Horizontal 6-tap quarter-pel affine interpolation: sliding sample window, shift-add taps, 3-stage sum/round.
// Optional output clamp to [0, 2^BITDEPTH-1] when AFFINE_QPEL_CLIP_EN is defined.
module affine_qpel_filter_pipe #(
    parameter int BITDEPTH = 10,
    parameter int ROW_LEN  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sof,
    input  logic [1:0]          in_frac,
    input  logic [BITDEPTH-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITDEPTH+1:0] out_data,
    output logic                out_eor
);

    localparam int PW = BITDEPTH + 8;
    localparam int OW = BITDEPTH + 2;
    localparam int CW = $clog2(ROW_LEN + 1);
    localparam logic signed [PW-1:0] RND  = PW'(32);
    localparam logic signed [OW-1:0] MAXV = OW'((1 << BITDEPTH) - 1);

    // Row index = fractional phase, column index = tap (tap 0 is the oldest sample).
    localparam int COEF [0:3][0:5] = '{
        '{0,   0, 64,  0,   0, 0},
        '{2,  -8, 58, 17,  -7, 2},
        '{3, -11, 40, 40, -11, 3},
        '{2,  -8, 17, 58,  -7, 2}
    };

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    function automatic logic signed [PW-1:0] shift_add(input int c, input logic [BITDEPTH-1:0] x);
        logic signed [PW-1:0] xs;
        logic signed [PW-1:0] r;
        xs = $signed({8'd0, x});
        case (c)
            2:       r = xs <<< 1;
            3:       r = (xs <<< 1) + xs;
            -7:      r = xs - (xs <<< 3);
            -8:      r = -(xs <<< 3);
            -11:     r = -((xs <<< 3) + (xs <<< 1) + xs);
            17:      r = (xs <<< 4) + xs;
            40:      r = (xs <<< 5) + (xs <<< 3);
            58:      r = (xs <<< 6) - (xs <<< 2) - (xs <<< 1);
            64:      r = xs <<< 6;
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t               state_reg, state_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [1:0]           phase_reg, phase_next;
    logic                 adv, xfer, shift_en, launch, launch_eor;

    logic [BITDEPTH-1:0]  win_reg [0:5];
    logic                 l_valid_reg, l_eor_reg;
    logic [1:0]           l_frac_reg;

    logic signed [PW-1:0] prod_next [0:5];
    logic signed [PW-1:0] prod_reg  [0:5];
    logic                 s1_valid_reg, s1_eor_reg;

    logic signed [PW-1:0] pair_next [0:2];
    logic signed [PW-1:0] pair_reg  [0:2];
    logic                 s2_valid_reg, s2_eor_reg;

    logic signed [PW-1:0] total;
    logic signed [OW-1:0] res, res_out;
    logic                 out_valid_reg, out_eor_reg;
    logic [OW-1:0]        out_data_reg;

    // One global advance: every stage moves together or holds together.
    assign adv       = !out_valid_reg | out_ready;
    assign in_ready  = adv;
    assign xfer      = in_valid & adv;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_eor   = out_eor_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            phase_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            phase_reg <= phase_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        phase_next = phase_reg;
        shift_en   = 1'b0;
        launch     = 1'b0;
        launch_eor = 1'b0;
        if (xfer) begin
            if (in_sof) begin
                // A start-of-row always restarts the window, aborting any row in progress.
                state_next = FILL;
                cnt_next   = CW'(1);
                phase_next = in_frac;
                shift_en   = 1'b1;
            end else if (state_reg != IDLE) begin
                shift_en = 1'b1;
                cnt_next = cnt_reg + CW'(1);
                if (cnt_next >= CW'(6)) begin
                    launch     = 1'b1;
                    state_next = RUN;
                end
                if (cnt_next == CW'(ROW_LEN)) begin
                    launch_eor = 1'b1;
                    state_next = IDLE;
                end
            end
        end
    end

    // Launch stage: sample window plus the tag of the window it represents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) win_reg[i] <= '0;
            l_valid_reg <= 1'b0;
            l_eor_reg   <= 1'b0;
            l_frac_reg  <= '0;
        end else if (adv) begin
            if (shift_en) begin
                for (int i = 0; i < 5; i++) win_reg[i] <= win_reg[i+1];
                win_reg[5] <= in_data;
            end
            l_valid_reg <= launch;
            l_eor_reg   <= launch_eor;
            l_frac_reg  <= phase_reg;
        end
    end

    for (genvar gi = 0; gi < 6; gi++) begin : g_tap
        assign prod_next[gi] = shift_add(COEF[l_frac_reg][gi], win_reg[gi]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) prod_reg[i] <= '0;
            s1_valid_reg <= 1'b0;
            s1_eor_reg   <= 1'b0;
        end else if (adv) begin
            for (int i = 0; i < 6; i++) prod_reg[i] <= prod_next[i];
            s1_valid_reg <= l_valid_reg;
            s1_eor_reg   <= l_eor_reg;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_pair
        assign pair_next[gi] = prod_reg[2*gi] + prod_reg[2*gi+1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) pair_reg[i] <= '0;
            s2_valid_reg <= 1'b0;
            s2_eor_reg   <= 1'b0;
        end else if (adv) begin
            for (int i = 0; i < 3; i++) pair_reg[i] <= pair_next[i];
            s2_valid_reg <= s1_valid_reg;
            s2_eor_reg   <= s1_eor_reg;
        end
    end

    assign total = pair_reg[0] + pair_reg[1] + pair_reg[2];
    assign res   = OW'((total + RND) >>> 6);

`ifdef AFFINE_QPEL_CLIP_EN
    always_comb begin
        res_out = res;
        if (res < 0) begin
            res_out = '0;
        end else if (res > MAXV) begin
            res_out = MAXV;
        end
    end
`else
    assign res_out = res;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_eor_reg   <= 1'b0;
            out_data_reg  <= '0;
        end else if (adv) begin
            out_valid_reg <= s2_valid_reg;
            out_eor_reg   <= s2_valid_reg & s2_eor_reg;
            out_data_reg  <= res_out;
        end
    end

endmodule

// File: tb/tb_affine_qpel_filter_pipe.sv
// Scoreboard bench for affine_qpel_filter_pipe: row-level reference model feeds a queue, a monitor pops on output transfers.
module tb_affine_qpel_filter_pipe;

    localparam int BD = 10;
    localparam int RL = 16;
    localparam int OW = BD + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_sof;
    logic [1:0]    in_frac;
    logic [BD-1:0] in_data;
    logic          out_valid, out_ready, out_eor;
    logic [OW-1:0] out_data;

    affine_qpel_filter_pipe #(.BITDEPTH(BD), .ROW_LEN(RL)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_frac(in_frac), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_eor(out_eor)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit eor;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rdy_mode = 0;

    // Reference model: the row so far as a plain list of samples.
    int   row_q[$];
    bit   row_active = 0;
    int   row_frac = 0;
    int   coef_tab [0:3][0:5] = '{
        '{0,   0, 64,  0,   0, 0},
        '{2,  -8, 58, 17,  -7, 2},
        '{3, -11, 40, 40, -11, 3},
        '{2,  -8, 17, 58,  -7, 2}
    };

    bit   seen_valid = 0;
    int   first_valid_cyc = 0;
    bit   held = 0;
    int   held_data = 0;
    bit   held_eor = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_push(input int x, input bit sof, input int frac);
        int   sum;
        int   r;
        int   n;
        exp_t e;
        if (sof) begin
            row_q.delete();
            row_q.push_back(x);
            row_active = 1;
            row_frac = frac;
        end else if (row_active) begin
            row_q.push_back(x);
            n = row_q.size();
            if (n >= 6) begin
                sum = 0;
                for (int k = 0; k < 6; k++) sum += coef_tab[row_frac][k] * row_q[n-6+k];
                r = (sum + 32) >>> 6;
`ifdef AFFINE_QPEL_CLIP_EN
                if (r < 0) r = 0;
                if (r > (1 << BD) - 1) r = (1 << BD) - 1;
`endif
                e.data = r;
                e.eor = (n == RL);
                sb.push_back(e);
                if (e.eor) row_active = 0;
            end
        end
    endfunction

    // Output readiness pattern, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = !out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: checks handshake rules, stall stability and scoreboard contents.
    always @(negedge clk) begin
        int   act;
        exp_t e;
        if (rst) begin
            held = 0;
        end else begin
            check("in_ready_rule", int'(in_ready), int'(!(out_valid && !out_ready)));
            if (held) begin
                act = $signed(out_data);
                check("stall_valid", int'(out_valid), 1);
                check("stall_data", act, held_data);
                check("stall_eor", int'(out_eor), int'(held_eor));
            end
            if (out_valid && !seen_valid) begin
                seen_valid = 1;
                first_valid_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                act = $signed(out_data);
                if (sb.size() == 0) begin
                    check("unexpected_output", act, -9999);
                end else begin
                    e = sb.pop_front();
                    $display("out data=%0d eor=%0d exp_data=%0d exp_eor=%0d", act, out_eor, e.data, e.eor);
                    check("out_data", act, e.data);
                    check("out_eor", int'(out_eor), int'(e.eor));
                end
            end
            held = out_valid && !out_ready;
            held_data = $signed(out_data);
            held_eor = out_eor;
        end
    end

    task automatic send(input int x, input bit sof, input int frac, output int acc);
        in_valid = 1'b1;
        in_data = BD'(x);
        in_sof = sof;
        in_frac = 2'(frac);
        acc = -1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc + 1;
                model_push(x, sof, frac);
                @(posedge clk);
                #1;
                return;
            end
        end
        check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sof = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        in_sof = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        repeat (4) @(negedge clk);
        check("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic const_row(input int v, input int frac, output int acc6);
        int acc;
        acc6 = -1;
        for (int i = 0; i < RL; i++) begin
            send(v, i == 0, frac, acc);
            if (i == 5) acc6 = acc;
        end
    endtask

    initial begin
        int acc, acc6, frac, len;
        rst = 1'b1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_frac = 2'd0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_out_eor", int'(out_eor), 0);
        check("reset_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Constant row, phase 2, with first-output latency.
        seen_valid = 0;
        const_row(100, 2, acc6);
        drain();
        check("latency_t1", first_valid_cyc - acc6, 3);

        // Impulse response, phase 1.
        for (int i = 0; i < RL; i++) send(i == 5 ? 64 : 0, i == 0, 1, acc);
        drain();

        // Full-scale single sample, phase 1 (negative lobes).
        for (int i = 0; i < RL; i++) send(i == 3 ? 1023 : 0, i == 0, 1, acc);
        drain();

        // Phase 3, random data, output stalled every other cycle.
        rdy_mode = 1;
        for (int i = 0; i < RL; i++) send($urandom_range(0, 1023), i == 0, 3, acc);
        drain();
        rdy_mode = 0;

        // Row A aborted after 8 samples by row B.
        for (int i = 0; i < 8; i++) send(i, i == 0, 0, acc);
        const_row(50, 2, acc6);
        drain();

        // Randomised rows: gaps, aborts, stray samples, random back-pressure.
        rdy_mode = 2;
        for (int r = 0; r < 8; r++) begin
            frac = $urandom_range(0, 3);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 12) : RL;
            if ($urandom_range(0, 2) == 0) send($urandom_range(0, 1023), 0, 0, acc);
            for (int i = 0; i < len; i++) begin
                send($urandom_range(0, 1023), i == 0, frac, acc);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        drain();
        rdy_mode = 0;

        // Reset in the middle of a row while output is valid.
        for (int i = 0; i < 9; i++) send(200 + i, i == 0, 2, acc);
        in_valid = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("pre_reset_valid", int'(out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_out_data", int'(out_data), 0);
        check("midreset_out_eor", int'(out_eor), 0);
        sb.delete();
        row_q.delete();
        row_active = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        seen_valid = 0;
        const_row(100, 2, acc6);
        drain();
        check("latency_t6", first_valid_cyc - acc6, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d required=0", 1);
        $fatal(1, "timeout");
    end

endmodule
